// File: rtl/abacus_pkg.sv
// Shared constants, state encoding and header helper for the ABACUS Wishbone sampler.
package abacus_pkg;

    localparam logic [31:0] OFS_EN_INSTR  = 32'h0000_0004;
    localparam logic [31:0] OFS_EN_CACHE  = 32'h0000_0008;
    localparam logic [31:0] OFS_INSTR_CNT = 32'h0000_0100;
    localparam logic [31:0] OFS_CACHE_CNT = 32'h0000_0200;
    localparam logic [7:0]  FRAME_MAGIC   = 8'hAB;

    typedef enum logic [2:0] {
        ST_INIT_EN0 = 3'd0,
        ST_INIT_EN1 = 3'd1,
        ST_IDLE     = 3'd2,
        ST_HDR      = 3'd3,
        ST_RD       = 3'd4,
        ST_PUSH     = 3'd5
    } sampler_state_t;

    function automatic logic [31:0] frame_header(input logic [7:0] words, input logic [15:0] seq);
        return {FRAME_MAGIC, words, seq};
    endfunction

endpackage

// File: rtl/abacus_wb_master_port.sv
// Single-access Wishbone initiator: registered bus signals, ack capture and an
// access timeout that completes the access with zero read data.
module abacus_wb_master_port #(
    parameter int WB_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack
);

    localparam logic [15:0] TMO_LAST = 16'(WB_TIMEOUT - 1);

    logic        cyc_r;
    logic        we_r;
    logic [31:0] adr_r;
    logic [31:0] dat_r;
    logic [31:0] rdata_r;
    logic        done_r;
    logic        timeout_r;
    logic [15:0] tmo_cnt_r;

    // Access handshake: done_r blocks a new strobe in the cycle after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r     <= 1'b0;
            we_r      <= 1'b0;
            adr_r     <= 32'h0000_0000;
            dat_r     <= 32'h0000_0000;
            rdata_r   <= 32'h0000_0000;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            tmo_cnt_r <= 16'h0000;
        end else begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            if (cyc_r) begin
                if (wb_ack) begin
                    cyc_r   <= 1'b0;
                    we_r    <= 1'b0;
                    done_r  <= 1'b1;
                    rdata_r <= wb_dat_i;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    cyc_r     <= 1'b0;
                    we_r      <= 1'b0;
                    done_r    <= 1'b1;
                    timeout_r <= 1'b1;
                    rdata_r   <= 32'h0000_0000;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + 16'd1;
                end
            end else if (req && !done_r) begin
                cyc_r     <= 1'b1;
                we_r      <= we;
                adr_r     <= adr & 32'hFFFF_FFFC;
                dat_r     <= wdata;
                tmo_cnt_r <= 16'h0000;
            end
        end
    end

    assign wb_cyc   = cyc_r;
    assign wb_stb   = cyc_r;
    assign wb_we    = we_r;
    assign wb_adr   = adr_r;
    assign wb_dat_o = dat_r;
    assign done     = done_r;
    assign rdata    = rdata_r;
    assign timeout  = timeout_r;

endmodule

// File: rtl/abacus_wb_sampler.sv
// Wishbone sampler for the ABACUS profiler: enables the profilers, then streams
// counter-snapshot frames (header + instruction + cache counters) on request.
module abacus_wb_sampler
    import abacus_pkg::*;
#(
    parameter logic [31:0] ABACUS_BASE_ADDR = 32'hF003_0000,
    parameter bit          ENABLE_ON_START  = 1'b1,
    parameter int          NUM_INSTR_CNT    = 11,
    parameter int          NUM_CACHE_CNT    = 8,
    parameter int unsigned SAMPLE_PERIOD    = 1000000,
    parameter int          WB_TIMEOUT       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_en,
    input  logic        sample_trig,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        wb_err,
    output logic [15:0] dropped
);

    localparam int             NUM_RD      = NUM_INSTR_CNT + NUM_CACHE_CNT;
    localparam logic [7:0]     FRAME_WORDS = 8'(1 + NUM_RD);
    localparam logic [7:0]     LAST_IDX    = 8'(NUM_RD - 1);
    localparam logic [7:0]     N_INSTR     = 8'(NUM_INSTR_CNT);
    localparam bit             TIMER_ON    = (SAMPLE_PERIOD != 32'd0);
    localparam logic [31:0]    PERIOD_LAST = 32'(SAMPLE_PERIOD - 32'd1);
    localparam sampler_state_t RESET_STATE = ENABLE_ON_START ? ST_INIT_EN0 : ST_IDLE;

    sampler_state_t state_r;
    sampler_state_t state_nx_s;

    logic        port_req_s;
    logic        port_we_s;
    logic [31:0] port_adr_s;
    logic [31:0] port_wdata_s;
    logic        port_done_s;
    logic [31:0] port_rdata_s;
    logic        port_timeout_s;

    logic [31:0] rd_adr_s;
    logic [31:0] timer_r;
    logic        tmr_hit_s;
    logic        req_s;
    logic        take_s;
    logic        pending_r;
    logic [15:0] dropped_r;
    logic        wb_err_r;
    logic        busy_r;
    logic        out_valid_r;
    logic [31:0] out_data_r;
    logic        out_last_r;
    logic [7:0]  idx_r;
    logic [15:0] seq_r;

    abacus_wb_master_port #(
        .WB_TIMEOUT (WB_TIMEOUT)
    ) u_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (port_req_s),
        .we       (port_we_s),
        .adr      (port_adr_s),
        .wdata    (port_wdata_s),
        .done     (port_done_s),
        .rdata    (port_rdata_s),
        .timeout  (port_timeout_s),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack   (wb_ack)
    );

    // Counter address for the current read index: instruction block, then cache block.
    always_comb begin
        if (idx_r < N_INSTR) begin
            rd_adr_s = ABACUS_BASE_ADDR + OFS_INSTR_CNT + {22'd0, idx_r, 2'b00};
        end else begin
            rd_adr_s = ABACUS_BASE_ADDR + OFS_CACHE_CNT + {22'd0, idx_r - N_INSTR, 2'b00};
        end
    end

    assign tmr_hit_s = sample_en && TIMER_ON && (timer_r == PERIOD_LAST);
    assign req_s     = sample_trig || tmr_hit_s;
    assign take_s    = (state_r == ST_IDLE) && pending_r;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Sequencer next state and access request.
    always_comb begin
        state_nx_s   = state_r;
        port_req_s   = 1'b0;
        port_we_s    = 1'b0;
        port_adr_s   = 32'h0000_0000;
        port_wdata_s = 32'h0000_0000;
        case (state_r)
            ST_INIT_EN0: begin
                port_req_s   = 1'b1;
                port_we_s    = 1'b1;
                port_adr_s   = ABACUS_BASE_ADDR + OFS_EN_INSTR;
                port_wdata_s = 32'h0000_0001;
                if (port_done_s) state_nx_s = ST_INIT_EN1;
                else             state_nx_s = ST_INIT_EN0;
            end
            ST_INIT_EN1: begin
                port_req_s   = 1'b1;
                port_we_s    = 1'b1;
                port_adr_s   = ABACUS_BASE_ADDR + OFS_EN_CACHE;
                port_wdata_s = 32'h0000_0001;
                if (port_done_s) state_nx_s = ST_IDLE;
                else             state_nx_s = ST_INIT_EN1;
            end
            ST_IDLE: begin
                if (pending_r) state_nx_s = ST_HDR;
                else           state_nx_s = ST_IDLE;
            end
            ST_HDR: begin
                if (out_ready) state_nx_s = ST_RD;
                else           state_nx_s = ST_HDR;
            end
            ST_RD: begin
                port_req_s = 1'b1;
                port_adr_s = rd_adr_s;
                if (port_done_s) state_nx_s = ST_PUSH;
                else             state_nx_s = ST_RD;
            end
            ST_PUSH: begin
                if (out_ready && out_last_r) state_nx_s = ST_IDLE;
                else if (out_ready)          state_nx_s = ST_RD;
                else                         state_nx_s = ST_PUSH;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Stream holding register, read index and frame sequence number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_last_r  <= 1'b0;
            idx_r       <= 8'd0;
            seq_r       <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pending_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= frame_header(FRAME_WORDS, seq_r);
                        out_last_r  <= 1'b0;
                        idx_r       <= 8'd0;
                    end
                end
                ST_HDR: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                ST_RD: begin
                    if (port_done_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= port_rdata_s;
                        out_last_r  <= (idx_r == LAST_IDX);
                    end
                end
                ST_PUSH: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (out_last_r) seq_r <= seq_r + 16'd1;
                        else            idx_r <= idx_r + 8'd1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Period timer; holds its value while sample_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= 32'd0;
        end else if (sample_en && TIMER_ON) begin
            if (timer_r == PERIOD_LAST) timer_r <= 32'd0;
            else                        timer_r <= timer_r + 32'd1;
        end
    end

    // Request capture: one pending slot, overflow counted in a saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
            dropped_r <= 16'd0;
        end else begin
            pending_r <= req_s || (pending_r && !take_s);
            if (req_s && pending_r && !take_s && (dropped_r != 16'hFFFF)) begin
                dropped_r <= dropped_r + 16'd1;
            end
        end
    end

    // Sticky timeout flag and busy indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            wb_err_r <= wb_err_r || port_timeout_s;
            busy_r   <= (state_nx_s != ST_IDLE);
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign wb_err    = wb_err_r;
    assign dropped   = dropped_r;

endmodule

// File: tb/tb_abacus_wb_sampler.sv
// Randomized self-checking bench for abacus_wb_sampler with a Wishbone slave model
// and a frame-level reference model.
`timescale 1ns/1ps
module tb_abacus_wb_sampler;

    localparam logic [31:0] BASE   = 32'hF003_0000;
    localparam logic [31:0] NONE   = 32'hFFFF_FFFC;
    localparam int          NI     = 11;
    localparam int          NC     = 8;
    localparam int          NW     = 1 + NI + NC;
    localparam int          PERIOD = 50;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n, sample_en, sample_trig;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic        out_valid, out_ready, out_last, busy, wb_err;
    logic [31:0] out_data;
    logic [15:0] dropped;

    int          n_vec = 0;
    int          n_err = 0;
    int          lat_min = 0, lat_max = 0, rdy_mode = 0;
    logic [31:0] key = 32'h0, noack_adr = NONE;
    logic [64:0] bus_q[$];
    logic [32:0] word_q[$];
    int          proto_errs = 0, stab_errs = 0, max_run = 0;
    logic [32:0] exp_w [NW];
    int          exp_seq = 0;
    bit          exp_err = 1'b0;

    abacus_wb_sampler #(
        .ABACUS_BASE_ADDR (BASE),
        .ENABLE_ON_START  (1'b1),
        .NUM_INSTR_CNT    (NI),
        .NUM_CACHE_CNT    (NC),
        .SAMPLE_PERIOD    (PERIOD),
        .WB_TIMEOUT       (TMO)
    ) dut (
        .clk (clk), .rst_n (rst_n), .sample_en (sample_en), .sample_trig (sample_trig),
        .wb_cyc (wb_cyc), .wb_stb (wb_stb), .wb_we (wb_we), .wb_adr (wb_adr),
        .wb_dat_o (wb_dat_o), .wb_dat_i (wb_dat_i), .wb_ack (wb_ack),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_last (out_last), .busy (busy), .wb_err (wb_err), .dropped (dropped)
    );

    always #5 clk = ~clk;

    // Wishbone slave: random latency, data = address ^ key, one address may never ack.
    int          lat = 0, lat_tgt = 0, run = 0;
    logic        prev_stb = 1'b0;
    logic [64:0] prev_bus;
    always @(negedge clk) begin
        if (!rst_n) begin
            wb_ack = 1'b0; wb_dat_i = 32'h0; lat = 0; run = 0; prev_stb = 1'b0;
        end else begin
            if (wb_ack && wb_cyc) proto_errs++;
            if (wb_cyc !== wb_stb || (wb_stb && wb_adr[1:0] != 2'b00)) proto_errs++;
            if (prev_stb && !wb_ack && wb_stb && ({wb_we, wb_adr, wb_dat_o} != prev_bus)) proto_errs++;
            if (wb_stb) run++;
            else begin
                if (run > max_run) max_run = run;
                run = 0;
            end
            prev_stb = wb_stb;
            prev_bus = {wb_we, wb_adr, wb_dat_o};
            if (wb_cyc && wb_stb && !wb_ack && wb_adr != noack_adr) begin
                if (lat >= lat_tgt) begin
                    wb_ack = 1'b1; wb_dat_i = wb_adr ^ key; bus_q.push_back(prev_bus);
                end else lat++;
            end else begin
                wb_ack = 1'b0; lat = 0; lat_tgt = $urandom_range(lat_max, lat_min);
            end
        end
    end

    // Stream sink: ready pattern per mode, transfer capture, stall-stability monitor.
    int          tick = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word;
    always @(negedge clk) begin
        if (!rst_n) begin
            out_ready = 1'b0; prev_stall = 1'b0;
        end else begin
            tick++;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (tick % 3 == 0);
                2:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = 1'b0;
            endcase
            if (prev_stall && (!out_valid || {out_last, out_data} != prev_word)) stab_errs++;
            if (out_valid && out_ready) word_q.push_back({out_last, out_data});
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    function automatic logic [31:0] rd_addr(input int i);
        if (i < NI) return BASE + 32'h100 + 32'(4 * i);
        else        return BASE + 32'h200 + 32'(4 * (i - NI));
    endfunction

    // Reference frame: header, then each counter (address ^ key, 0 if never acked).
    function automatic void build_frame(input int seq, input logic [31:0] k, input logic [31:0] na);
        exp_w[0] = {1'b0, 8'hAB, 8'(NW), 16'(seq)};
        for (int i = 0; i < NW - 1; i++)
            exp_w[i + 1] = {(i == NW - 2), (rd_addr(i) == na) ? 32'h0 : (rd_addr(i) ^ k)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && word_q.size() < n; c++) cyc(1);
        if (word_q.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_init(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            cyc(1);
            if (bus_q.size() >= 2 && busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic pulse_trig();
        sample_trig = 1'b1; cyc(1); sample_trig = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; sample_en = 1'b0; sample_trig = 1'b0; lat_min = 0; lat_max = 0;
        cyc(3);
        n_vec++;
        if ({wb_cyc, wb_stb, wb_we, out_valid, out_last, busy, wb_err} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 0000000", {wb_cyc, wb_stb, wb_we, out_valid, out_last, busy, wb_err});
        end
        n_vec++;
        if (dropped !== 16'd0 || wb_adr !== 32'h0 || wb_dat_o !== 32'h0 || out_data !== 32'h0) begin
            n_err++; $display("FAIL reset_data dropped=%h adr=%h dat=%h out=%h want all 0", dropped, wb_adr, wb_dat_o, out_data);
        end
        bus_q.delete(); word_q.delete();
        rst_n = 1'b1;
        wait_init(ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL init_done got %0d writes busy=%b want 2 writes busy=0", bus_q.size(), busy); end
        n_vec++;
        if (bus_q.size() != 2 || bus_q[0] !== {1'b1, BASE + 32'h4, 32'h1} || bus_q[1] !== {1'b1, BASE + 32'h8, 32'h1}) begin
            n_err++; $display("FAIL init_writes got %0d entries first=%h want 2 writes of 1 to base+4, base+8", bus_q.size(), bus_q[0]);
        end
        cyc(5);
        n_vec++;
        if (word_q.size() != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL init_quiet got words=%0d busy=%b want 0 and 0", word_q.size(), busy);
        end
    endtask

    task automatic test_frame(input string tag, input int mode, input int lmax,
                              input logic [31:0] k, input logic [31:0] na);
        bit ok;
        int j;
        word_q.delete(); bus_q.delete();
        rdy_mode = mode; lat_min = 0; lat_max = lmax; key = k; noack_adr = na;
        proto_errs = 0; stab_errs = 0; max_run = 0;
        if (na != NONE) exp_err = 1'b1;
        cyc(2);
        pulse_trig();
        wait_words(NW, 2000, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL %s_len got %0d words want %0d", tag, word_q.size(), NW); end
        build_frame(exp_seq, k, na);
        for (int i = 0; i < NW && i < word_q.size(); i++) begin
            n_vec++;
            if (word_q[i] !== exp_w[i]) begin
                n_err++; $display("FAIL %s_word%0d got %h want %h", tag, i, word_q[i], exp_w[i]);
            end
        end
        cyc(TMO + 10);
        n_vec++;
        if (word_q.size() != NW || busy !== 1'b0) begin
            n_err++; $display("FAIL %s_end got words=%0d busy=%b want %0d and 0", tag, word_q.size(), busy, NW);
        end
        j = 0;
        for (int i = 0; i < NW - 1; i++) begin
            if (rd_addr(i) != na) begin
                n_vec++;
                if (j >= bus_q.size() || bus_q[j][64:32] !== {1'b0, rd_addr(i)}) begin
                    n_err++; $display("FAIL %s_read%0d got %h want read of %h", tag, i, bus_q[j], rd_addr(i));
                end
                j++;
            end
        end
        n_vec++;
        if (proto_errs != 0 || stab_errs != 0) begin
            n_err++; $display("FAIL %s_proto got bus=%0d stream=%0d violations want 0", tag, proto_errs, stab_errs);
        end
        n_vec++;
        if (wb_err !== exp_err) begin n_err++; $display("FAIL %s_wb_err got %b want %b", tag, wb_err, exp_err); end
        n_vec++;
        if ((na != NONE && max_run != TMO) || (na == NONE && max_run > lmax + 1)) begin
            n_err++; $display("FAIL %s_stb_len got %0d cycles want %0d", tag, max_run, (na != NONE) ? TMO : lmax + 1);
        end
        exp_seq++;
        noack_adr = NONE;
    endtask

    task automatic test_timer_drop();
        bit ok;
        word_q.delete(); stab_errs = 0;
        rdy_mode = 3; lat_min = 0; lat_max = 2; key = $urandom;
        cyc(2);
        sample_en = 1'b1;
        for (int c = 1; c <= 5 * PERIOD; c++) begin
            if (c == 5 * PERIOD) sample_trig = 1'b1;
            cyc(1);
            if (c == 4 * PERIOD) begin
                n_vec++;
                if (dropped !== 16'(c / PERIOD - 2)) begin
                    n_err++; $display("FAIL timer_dropped got %0d want %0d", dropped, c / PERIOD - 2);
                end
            end
        end
        sample_trig = 1'b0; sample_en = 1'b0;
        n_vec++;
        if (dropped !== 16'd3) begin n_err++; $display("FAIL trig_timer_once got %0d want 3", dropped); end
        build_frame(exp_seq, key, NONE);
        n_vec++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || {out_last, out_data} !== exp_w[0] || word_q.size() != 0) begin
            n_err++; $display("FAIL stall_hdr got busy=%b valid=%b data=%h words=%0d want 1 1 %h 0", busy, out_valid, out_data, word_q.size(), exp_w[0][31:0]);
        end
        rdy_mode = 0;
        wait_words(2 * NW, 3000, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL drain_len got %0d words want %0d", word_q.size(), 2 * NW); end
        for (int f = 0; f < 2; f++) begin
            build_frame(exp_seq + f, key, NONE);
            for (int i = 0; i < NW && f * NW + i < word_q.size(); i++) begin
                n_vec++;
                if (word_q[f * NW + i] !== exp_w[i]) begin
                    n_err++; $display("FAIL drain_f%0d_word%0d got %h want %h", f, i, word_q[f * NW + i], exp_w[i]);
                end
            end
        end
        exp_seq += 2;
        cyc(40);
        n_vec++;
        if (word_q.size() != 2 * NW || busy !== 1'b0 || stab_errs != 0) begin
            n_err++; $display("FAIL drain_end got words=%0d busy=%b unstable=%0d want %0d 0 0", word_q.size(), busy, stab_errs, 2 * NW);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        word_q.delete(); rdy_mode = 0; lat_min = 6; lat_max = 8;
        pulse_trig();
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            cyc(1);
            if (wb_cyc === 1'b1 && wb_we === 1'b0) ok = 1'b1;
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL midrst_read got no read cycle want one"); end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({wb_cyc, wb_stb, out_valid, busy} !== 4'b0) begin
            n_err++; $display("FAIL midrst_async got cyc/stb/valid/busy=%b want 0000", {wb_cyc, wb_stb, out_valid, busy});
        end
        cyc(2);
        bus_q.delete(); word_q.delete(); lat_min = 0; lat_max = 2; key = $urandom;
        exp_seq = 0; exp_err = 1'b0;
        rst_n = 1'b1;
        wait_init(ok);
        n_vec++;
        if (!ok || bus_q[0] !== {1'b1, BASE + 32'h4, 32'h1} || bus_q[1] !== {1'b1, BASE + 32'h8, 32'h1}) begin
            n_err++; $display("FAIL midrst_init got %0d entries first=%h want init rerun", bus_q.size(), bus_q[0]);
        end
        n_vec++;
        if (wb_err !== 1'b0 || dropped !== 16'd0) begin
            n_err++; $display("FAIL midrst_flags got wb_err=%b dropped=%0d want 0 0", wb_err, dropped);
        end
        pulse_trig();
        wait_words(NW, 1000, ok);
        build_frame(0, key, NONE);
        n_vec++;
        if (!ok || word_q[0] !== exp_w[0] || word_q[NW - 1] !== exp_w[NW - 1]) begin
            n_err++; $display("FAIL midrst_frame got hdr=%h last=%h want %h %h", word_q[0], word_q[NW - 1], exp_w[0], exp_w[NW - 1]);
        end
    endtask

    initial begin
        test_reset();
        test_frame("frame", 0, 0, 32'h0, NONE);
        test_frame("stall", 1, 3, $urandom, NONE);
        test_frame("timeout", 2, 3, $urandom, BASE + 32'h108);
        test_timer_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
